data_mem_arbiter: RTL and testbench
===================================

// Module: data_mem_arbiter
// PURPOSE
// - Shares one data_mem (single port, registered read) between two requesters (r0, r1), e.g. point writer and point reader.
// - Round-robin arbitration with bounded burst ownership and a valid/ready request handshake.
// - Drives data_mem from registers; returns read data with a per-requester response strobe.
// PARAMETERS
// - DATA_WIDTH  8  word width of data_mem
// - ADDR_WIDTH  8  address width of data_mem
// - MAX_BURST   4  max consecutive beats one owner keeps while the other requester waits (>=1)
// PORTS
// - clk          in   1           clock, all state on posedge
// - rstn         in   1           reset, asynchronous, active-low
// - rN_valid     in   1           requester N (N=0,1) has a command
// - rN_ready     out  1           command accepted this cycle when rN_valid && rN_ready
// - rN_wEn       in   1           1 = write, 0 = read
// - rN_addr      in   ADDR_WIDTH  address
// - rN_data      in   DATA_WIDTH  write data
// - rN_rvalid    out  1           rd_data holds requester N's read result this cycle
// - rd_data      out  DATA_WIDTH  = mem_out (shared return bus)
// - mem_addr     out  ADDR_WIDTH  to data_mem addr
// - mem_data     out  DATA_WIDTH  to data_mem data
// - mem_wEn      out  1           to data_mem wEn
// - mem_rEn      out  1           to data_mem rEn
// - mem_out      in   DATA_WIDTH  from data_mem mem_out
// BEHAVIOUR
// - Reset (async, rstn=0): state=IDLE, rr_ptr=0 (r0 favoured first), beat_cnt=0, mem_wEn=mem_rEn=0,
//   mem_addr=mem_data=0, r0/r1_ready=0, r0/r1_rvalid=0. In-flight read responses are dropped.
// - States: IDLE, OWN0, OWN1. rN_ready = (state==OWNN), decoded from state register only (no valid->ready path).
// - IDLE: neither valid -> IDLE. Only rN valid -> OWNN. Both valid -> OWN[rr_ptr].
//   One bubble cycle from first valid to first ready.
// - OWNN, rN_valid=1: beat accepted; beat_cnt++.
//   - If beat_cnt==MAX_BURST-1 on accept and other valid: -> OWN(other), beat_cnt=0, rr_ptr=N+1.
//   - If beat_cnt==MAX_BURST-1 and other idle: stay OWNN, beat_cnt=0.
// - OWNN, rN_valid=0: other valid -> OWN(other), beat_cnt=0, rr_ptr=other; else -> IDLE, beat_cnt=0, rr_ptr=other.
// - Command issue: accept sampled at edge E0 -> mem_addr/mem_data/mem_wEn/mem_rEn registered at E0.
//   - mem_wEn=rN_wEn, mem_rEn=~rN_wEn; both 0 in any cycle with no accept.
//   - data_mem samples at E1.
// - Read response: rd_valid_pipe set at E1 for reads -> rN_rvalid high the cycle after E1 (2 cycles after accept),
//   exactly one cycle, tagged with the accepting requester. rd_data = mem_out combinational.
// - Writes produce no rvalid. Throughput 1 beat/cycle while ownership is held; owner switch costs 0 bubbles.
// - Back-to-back read/write to the same address: order preserved (single in-order pipe); a read after a write
//   returns the new data.
// - mem_wEn and mem_rEn are never both 1.
// - Parameter check: MAX_BURST==1 gives strict alternation when both requesters are valid.
// STRUCTURE
// - Shared package pointcloud_pkg: state encoding (IDLE=2'd0, OWN0=2'd1, OWN1=2'd2), DATA_WIDTH/ADDR_WIDTH
//   defaults shared with data_mem.
// - Single module, no sub-module: FSM + beat counter ($clog2(MAX_BURST) bits) + 1-stage issue register
//   + 1-bit response tag pipe.
// - Bench instantiates data_mem_arbiter + data_mem together.
// TESTING
// - Reset: rstn=0 mid-burst (r0 read in flight) -> all outputs 0 immediately; no r0_rvalid after release.
// - Single write/read: r0 writes addr 0 data 32, addr 1 data 33, then reads addr 1 -> r0_rvalid 2 cycles after
//   read accept, rd_data=33.
// - Contention: r0,r1 continuously valid from IDLE, MAX_BURST=4 -> r0 gets 4 beats, r1 4 beats, alternating;
//   no idle cycle on mem between bursts.
// - Early release: r1 owns, drops valid after 2 beats while r0 valid -> OWN0 next cycle, beat_cnt restarts at 0.
// - Response tagging: r0 reads addr 2 (34), r1 reads addr 0 (32) on consecutive cycles -> r0_rvalid with 34,
//   then r1_rvalid with 32; never both high.
// - Random: 1000 cycles of random valid/wEn/addr/data on both ports vs. scoreboard memory model ->
//   all read data match, mem_wEn&mem_rEn never 1, no requester starved > MAX_BURST beats.

Source files
------------

// File: rtl/pointcloud_pkg.sv
// Shared definitions for the point-cloud datapath: data_mem geometry defaults and arbiter state encoding.
package pointcloud_pkg;

  localparam int PC_DATA_WIDTH = 8;
  localparam int PC_ADDR_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

endpackage

// File: rtl/data_mem.sv
// Single-port data memory with a registered read port; writes land on the clock edge.
// mem_out holds the last read word and clears on reset (array contents are not reset).
module data_mem
  import pointcloud_pkg::*;
#(
  parameter int DATA_WIDTH = PC_DATA_WIDTH,
  parameter int ADDR_WIDTH = PC_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  wEn,
  input  logic                  rEn,
  output logic [DATA_WIDTH-1:0] mem_out
);

  logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] r_out;

  always_ff @(posedge clk) begin
    if (wEn) r_mem[addr] <= data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)    r_out <= '0;
    else if (rEn) r_out <= r_mem[addr];
  end

  assign mem_out = r_out;

endmodule

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing one data_mem between two requesters, with bounded burst ownership.
// Command issues one cycle after accept; read data returns two cycles after accept with a per-requester strobe.
module data_mem_arbiter
  import pointcloud_pkg::*;
#(
  parameter int DATA_WIDTH = PC_DATA_WIDTH,
  parameter int ADDR_WIDTH = PC_ADDR_WIDTH,
  parameter int MAX_BURST  = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  r0_valid,
  output logic                  r0_ready,
  input  logic                  r0_wEn,
  input  logic [ADDR_WIDTH-1:0] r0_addr,
  input  logic [DATA_WIDTH-1:0] r0_data,
  output logic                  r0_rvalid,
  input  logic                  r1_valid,
  output logic                  r1_ready,
  input  logic                  r1_wEn,
  input  logic [ADDR_WIDTH-1:0] r1_addr,
  input  logic [DATA_WIDTH-1:0] r1_data,
  output logic                  r1_rvalid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_wEn,
  output logic                  mem_rEn,
  input  logic [DATA_WIDTH-1:0] mem_out
);

  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  arb_state_t            r_state, w_state_nxt;
  logic                  r_rr_ptr, w_rr_nxt;
  logic [CNT_W-1:0]      r_beat_cnt, w_beat_nxt;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_data;
  logic                  r_mem_wen, r_mem_ren, r_iss_tag;
  logic                  r_rd_vld, r_rd_tag;

  logic w_own1, w_my_vld, w_oth_vld, w_acc, w_last;

  assign w_own1    = (r_state == OWN1);
  assign w_my_vld  = w_own1 ? r1_valid : r0_valid;
  assign w_oth_vld = w_own1 ? r0_valid : r1_valid;
  assign w_acc     = (r_state != IDLE) && w_my_vld;
  assign w_last    = (r_beat_cnt == CNT_W'(MAX_BURST - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_rr_nxt    = r_rr_ptr;
    w_beat_nxt  = r_beat_cnt;
    case (r_state)
      IDLE: begin
        if (r0_valid && r1_valid) w_state_nxt = r_rr_ptr ? OWN1 : OWN0;
        else if (r0_valid)        w_state_nxt = OWN0;
        else if (r1_valid)        w_state_nxt = OWN1;
      end
      OWN0, OWN1: begin
        if (w_my_vld) begin
          if (w_last) begin
            w_beat_nxt = '0;
            // Burst exhausted: hand over only if the other side is waiting.
            if (w_oth_vld) begin
              w_state_nxt = w_own1 ? OWN0 : OWN1;
              w_rr_nxt    = ~w_own1;
            end
          end else begin
            w_beat_nxt = r_beat_cnt + CNT_W'(1);
          end
        end else begin
          w_beat_nxt = '0;
          w_rr_nxt   = ~w_own1;
          if (w_oth_vld) w_state_nxt = w_own1 ? OWN0 : OWN1;
          else           w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= IDLE;
      r_rr_ptr   <= 1'b0;
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_rr_ptr   <= w_rr_nxt;
      r_beat_cnt <= w_beat_nxt;
    end
  end

  // Issue register and response tag pipe form one in-order path, so read-after-write ordering holds.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_mem_addr <= '0;
      r_mem_data <= '0;
      r_mem_wen  <= 1'b0;
      r_mem_ren  <= 1'b0;
      r_iss_tag  <= 1'b0;
      r_rd_vld   <= 1'b0;
      r_rd_tag   <= 1'b0;
    end else begin
      if (w_acc) begin
        r_mem_addr <= w_own1 ? r1_addr : r0_addr;
        r_mem_data <= w_own1 ? r1_data : r0_data;
        r_mem_wen  <= w_own1 ? r1_wEn : r0_wEn;
        r_mem_ren  <= w_own1 ? ~r1_wEn : ~r0_wEn;
        r_iss_tag  <= w_own1;
      end else begin
        r_mem_wen  <= 1'b0;
        r_mem_ren  <= 1'b0;
      end
      r_rd_vld <= r_mem_ren;
      r_rd_tag <= r_iss_tag;
    end
  end

  assign r0_ready  = (r_state == OWN0);
  assign r1_ready  = (r_state == OWN1);
  assign mem_addr  = r_mem_addr;
  assign mem_data  = r_mem_data;
  assign mem_wEn   = r_mem_wen;
  assign mem_rEn   = r_mem_ren;
  assign r0_rvalid = r_rd_vld & ~r_rd_tag;
  assign r1_rvalid = r_rd_vld & r_rd_tag;
  assign rd_data   = mem_out;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter driving a real data_mem; scoreboard of expected read responses.
module tb_data_mem_arbiter;

  localparam int MB = 4;

  logic       clk = 1'b0;
  logic       rstn;
  logic       r0_valid, r0_wEn, r1_valid, r1_wEn;
  logic [7:0] r0_addr, r0_data, r1_addr, r1_data;
  logic       r0_ready, r1_ready, r0_rvalid, r1_rvalid;
  logic [7:0] rd_data, mem_addr, mem_data, mem_out;
  logic       mem_wEn, mem_rEn;

  data_mem_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .MAX_BURST(MB)) dut (
    .clk(clk), .rstn(rstn),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_wEn(r0_wEn), .r0_addr(r0_addr),
    .r0_data(r0_data), .r0_rvalid(r0_rvalid),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_wEn(r1_wEn), .r1_addr(r1_addr),
    .r1_data(r1_data), .r1_rvalid(r1_rvalid),
    .rd_data(rd_data), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_wEn(mem_wEn), .mem_rEn(mem_rEn), .mem_out(mem_out)
  );

  data_mem #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) u_mem (
    .clk(clk), .rstn(rstn), .addr(mem_addr), .data(mem_data),
    .wEn(mem_wEn), .rEn(mem_rEn), .mem_out(mem_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic       tag;
    logic [7:0] dat;
    int         cyc;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] model [256];
  int         n_checks = 0;
  int         n_errors = 0;
  bit         log_en = 0;
  int         lg_own[$], lg_cyc[$], rsp_tag[$], rsp_dat[$], rsp_cyc[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic rdy(input int n);
    return (n == 1) ? r1_ready : r0_ready;
  endfunction

  task automatic drive(input int n, input logic v, input logic w, input logic [7:0] a, input logic [7:0] d);
    if (n == 1) begin r1_valid = v; r1_wEn = w; r1_addr = a; r1_data = d; end
    else        begin r0_valid = v; r0_wEn = w; r0_addr = a; r0_data = d; end
  endtask

  task automatic idle(input int n);
    drive(n, 1'b0, 1'b0, 8'd0, 8'd0);
  endtask

  // Hold a command until accepted; returns at #1 after the accepting edge.
  task automatic send(input int n, input logic w, input logic [7:0] a, input logic [7:0] d);
    bit got = 0;
    drive(n, 1'b1, w, a, d);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rdy(n)) begin got = 1; break; end
    end
    if (got) begin @(posedge clk); #1; end
    else chk("send_timeout", 0, 1);
  endtask

  task automatic clear_logs();
    lg_own.delete(); lg_cyc.delete(); rsp_tag.delete(); rsp_dat.delete(); rsp_cyc.delete();
  endtask

  task automatic do_reset();
    rstn = 1'b0; idle(0); idle(1);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic mon();
    int   w0 = 0, w1 = 0, n;
    logic a0, a1;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rstn) begin sb_q.delete(); w0 = 0; w1 = 0; continue; end
      if (r0_rvalid || r1_rvalid) begin
        chk("rvalid_both", r0_rvalid & r1_rvalid, 0);
        if (sb_q.size() == 0) chk("rvalid_unexpected", {r0_rvalid, r1_rvalid}, 0);
        else begin
          e = sb_q.pop_front();
          chk("resp_tag", r1_rvalid, e.tag);
          chk("resp_data", rd_data, e.dat);
          chk("resp_latency", cyc, e.cyc + 2);
        end
        if (log_en) begin
          rsp_tag.push_back(int'(r1_rvalid)); rsp_dat.push_back(int'(rd_data)); rsp_cyc.push_back(cyc);
        end
      end
      if (mem_wEn || mem_rEn) chk("wen_ren_excl", mem_wEn & mem_rEn, 0);
      a0 = r0_valid && r0_ready;
      a1 = r1_valid && r1_ready;
      if (a0 || a1) begin
        chk("single_owner", a0 & a1, 0);
        n = a1 ? 1 : 0;
        if (a1 ? r1_wEn : r0_wEn) model[a1 ? r1_addr : r0_addr] = a1 ? r1_data : r0_data;
        else sb_q.push_back('{tag: a1, dat: model[a1 ? r1_addr : r0_addr], cyc: cyc});
        if (log_en) begin lg_own.push_back(n); lg_cyc.push_back(cyc); end
      end
      if (r0_valid && !a0 && a1) begin w0++; chk("starve_r0", w0 <= MB, 1); end
      else if (!r0_valid || a0) w0 = 0;
      if (r1_valid && !a1 && a0) begin w1++; chk("starve_r1", w1 <= MB, 1); end
      else if (!r1_valid || a1) w1 = 0;
    end
  endtask

  task automatic rnd(input int n);
    bit took = 0;
    bit cur_v = 0;
    for (int k = 0; k < 1000; k++) begin
      if (!cur_v || took) begin
        cur_v = ($urandom_range(0, 3) != 0);
        drive(n, cur_v, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
      end
      @(negedge clk);
      took = cur_v && rdy(n);
      @(posedge clk); #1;
    end
    idle(n);
  endtask

  initial begin
    int c0;
    int exp_own[10] = '{1, 1, 0, 0, 0, 0, 1, 1, 0, 0};
    rstn = 1'b0;
    idle(0); idle(1);
    fork mon(); join_none
    repeat (2) @(posedge clk); #1;
    chk("rst_ready", {r0_ready, r1_ready}, 0);
    chk("rst_rvalid", {r0_rvalid, r1_rvalid}, 0);
    chk("rst_men", {mem_wEn, mem_rEn}, 0);
    chk("rst_maddr", mem_addr, 0);
    chk("rst_mdata", mem_data, 0);
    chk("rst_rdata", rd_data, 0);
    rstn = 1'b1;
    repeat (2) @(posedge clk); #1;

    // Reset with a read just issued: everything clears at once, no late response.
    send(0, 1'b1, 8'd7, 8'd77);
    send(0, 1'b0, 8'd7, 8'd0);
    rstn = 1'b0; idle(0);
    #1;
    chk("midrst_men", {mem_wEn, mem_rEn}, 0);
    chk("midrst_ready", {r0_ready, r1_ready}, 0);
    chk("midrst_rvalid", {r0_rvalid, r1_rvalid}, 0);
    repeat (2) @(posedge clk); #1 rstn = 1'b1;
    clear_logs(); log_en = 1;
    repeat (6) @(posedge clk); #1;
    chk("midrst_no_resp", rsp_tag.size(), 0);

    // Single requester write then read-back.
    clear_logs();
    send(0, 1'b1, 8'd0, 8'd32);
    send(0, 1'b1, 8'd1, 8'd33);
    send(0, 1'b1, 8'd2, 8'd34);
    send(0, 1'b0, 8'd1, 8'd0);
    idle(0);
    repeat (4) @(posedge clk); #1;
    chk("wr_rd_count", rsp_dat.size(), 1);
    if (rsp_dat.size() >= 1 && lg_cyc.size() >= 4) begin
      chk("wr_rd_data", rsp_dat[0], 33);
      chk("wr_rd_tag", rsp_tag[0], 0);
      chk("wr_rd_lat", rsp_cyc[0] - lg_cyc[3], 2);
    end

    // Contention from a fresh reset: r0 favoured first, 4-beat bursts, no gaps.
    do_reset();
    clear_logs();
    c0 = cyc;
    fork
      begin for (int i = 0; i < 8; i++) send(0, 1'b1, 8'(20 + i), 8'(100 + i)); idle(0); end
      begin for (int i = 0; i < 8; i++) send(1, 1'b1, 8'(40 + i), 8'(200 + i)); idle(1); end
    join
    repeat (2) @(posedge clk); #1;
    chk("cont_beats", lg_own.size(), 16);
    if (lg_own.size() == 16) begin
      chk("cont_bubble", lg_cyc[0], c0 + 1);
      for (int i = 0; i < 16; i++) begin
        chk("cont_owner", lg_own[i], (i / 4) % 2);
        chk("cont_no_gap", lg_cyc[i], lg_cyc[0] + i);
      end
    end

    // Early release by r1 after 2 beats; r0's burst count starts fresh.
    clear_logs();
    fork
      begin
        send(1, 1'b1, 8'd50, 8'd1); send(1, 1'b1, 8'd51, 8'd2); idle(1);
        @(posedge clk); #1;
        send(1, 1'b1, 8'd52, 8'd3); send(1, 1'b1, 8'd53, 8'd4); idle(1);
      end
      begin
        repeat (2) @(posedge clk); #1;
        for (int i = 0; i < 6; i++) send(0, 1'b1, 8'(60 + i), 8'(i));
        idle(0);
      end
    join
    repeat (2) @(posedge clk); #1;
    chk("early_beats", lg_own.size(), 10);
    if (lg_own.size() == 10) begin
      for (int i = 0; i < 10; i++) chk("early_owner", lg_own[i], exp_own[i]);
      chk("early_switch", lg_cyc[2], lg_cyc[1] + 2);
    end

    // Response tagging across a zero-bubble owner switch.
    clear_logs();
    fork
      begin
        send(0, 1'b1, 8'd10, 8'd0); send(0, 1'b1, 8'd11, 8'd0); send(0, 1'b1, 8'd12, 8'd0);
        send(0, 1'b0, 8'd2, 8'd0); idle(0);
      end
      begin repeat (2) @(posedge clk); #1; send(1, 1'b0, 8'd0, 8'd0); idle(1); end
    join
    repeat (4) @(posedge clk); #1;
    chk("tag_count", rsp_tag.size(), 2);
    if (rsp_tag.size() == 2 && lg_cyc.size() == 5) begin
      chk("tag_first", rsp_tag[0], 0);
      chk("tag_first_data", rsp_dat[0], 34);
      chk("tag_second", rsp_tag[1], 1);
      chk("tag_second_data", rsp_dat[1], 32);
      chk("tag_back2back", rsp_cyc[1], rsp_cyc[0] + 1);
      chk("tag_switch", lg_cyc[4], lg_cyc[3] + 1);
    end

    // Random traffic over a preloaded window of 16 addresses.
    log_en = 0;
    for (int i = 0; i < 16; i++) send(0, 1'b1, 8'(i), 8'($urandom_range(0, 255)));
    idle(0);
    fork
      rnd(0);
      rnd(1);
    join
    repeat (5) @(posedge clk); #1;
    chk("sb_drain", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
